// File: rtl/sdram_port_arb_if.sv
// Client-side and controller-side bus bundle for the SDRAM port arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface sdram_port_arb_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned AW     = 24
);
  logic                 init_done;
  logic [NUM_CH*DW-1:0] ch_wr_data;
  logic [NUM_CH*AW-1:0] ch_wr_addr;
  logic [NUM_CH-1:0]    ch_wr_valid;
  logic [NUM_CH-1:0]    ch_wr_ready;
  logic [NUM_CH*AW-1:0] ch_rd_addr;
  logic [NUM_CH-1:0]    ch_rd_avalid;
  logic [NUM_CH-1:0]    ch_rd_aready;
  logic [NUM_CH*DW-1:0] ch_rd_data;
  logic [NUM_CH-1:0]    ch_rd_valid;
  logic [NUM_CH-1:0]    ch_rd_ready;
  logic [DW-1:0]        m_wr_data;
  logic [AW-1:0]        m_wr_addr;
  logic                 m_wr_valid;
  logic                 m_wr_ready;
  logic [AW-1:0]        m_rd_addr;
  logic                 m_rd_avalid;
  logic                 m_rd_aready;
  logic [DW-1:0]        m_rd_data;
  logic                 m_rd_valid;
  logic                 m_rd_ready;
  logic                 err_orphan;

  modport slave (
    input  init_done, ch_wr_data, ch_wr_addr, ch_wr_valid, ch_rd_addr, ch_rd_avalid, ch_rd_ready,
    input  m_wr_ready, m_rd_aready, m_rd_data, m_rd_valid,
    output ch_wr_ready, ch_rd_aready, ch_rd_data, ch_rd_valid,
    output m_wr_data, m_wr_addr, m_wr_valid, m_rd_addr, m_rd_avalid, m_rd_ready, err_orphan
  );

  modport master (
    output init_done, ch_wr_data, ch_wr_addr, ch_wr_valid, ch_rd_addr, ch_rd_avalid, ch_rd_ready,
    output m_wr_ready, m_rd_aready, m_rd_data, m_rd_valid,
    input  ch_wr_ready, ch_rd_aready, ch_rd_data, ch_rd_valid,
    input  m_wr_data, m_wr_addr, m_wr_valid, m_rd_addr, m_rd_avalid, m_rd_ready, err_orphan
  );
endinterface

// File: rtl/sdram_port_arb.sv
// Round-robin multiplexer of NUM_CH write/read client ports onto one SDRAM controller port,
// with a same-slot burst lock and an in-order tag FIFO that routes read data back to its channel.
module sdram_port_arb #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned DW        = 16,
  parameter int unsigned AW        = 24,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned MAX_BEATS = 4
) (
  input logic             clk,
  input logic             rst,
  sdram_port_arb_if.slave bus
);
  localparam int unsigned NS = 2 * NUM_CH;
  localparam int unsigned SW = $clog2(NS);
  localparam int unsigned CW = $clog2(NUM_CH);
  localparam int unsigned PW = $clog2(MAX_OUTST);
  localparam int unsigned BW = $clog2(MAX_BEATS + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;

  logic [1:0]    state_q;
  logic [SW-1:0] ptr_q, last_q;
  logic [BW-1:0] beat_q;
  logic [DW-1:0] wr_data_q;
  logic [AW-1:0] wr_addr_q, rd_addr_q;
  logic          wr_valid_q, rd_avalid_q;
  logic [CW-1:0] ch_q;
  logic          err_q;

  logic [CW-1:0] tag_mem [MAX_OUTST];
  logic [PW-1:0] tag_wr_q, tag_rd_q;
  logic [PW:0]   tag_cnt_q;
  logic          tag_full, tag_empty, tag_push, tag_pop;
  logic [CW-1:0] head;

  logic [NS-1:0] elig;
  logic          lock, found, grant, sel_rd;
  logic [SW-1:0] rr_sel, sel, sel_nxt;
  logic [CW-1:0] sel_ch;

  assign tag_full  = tag_cnt_q == (PW+1)'(MAX_OUTST);
  assign tag_empty = tag_cnt_q == '0;
  assign head      = tag_mem[tag_rd_q];

  // Even slots are channel writes, odd slots channel reads.
  always_comb begin
    for (int unsigned s = 0; s < NS; s++) begin
      elig[s] = bus.init_done &&
                ((s % 2 == 1) ? (bus.ch_rd_avalid[s/2] && !tag_full) : bus.ch_wr_valid[s/2]);
    end
  end

  always_comb begin
    found  = 1'b0;
    rr_sel = '0;
    for (int unsigned k = 0; k < NS; k++) begin
      if (!found && elig[(ptr_q + k) % NS]) begin
        found  = 1'b1;
        rr_sel = SW'((ptr_q + k) % NS);
      end
    end
    // beat_q == 0 only after reset, where there is no previous slot to hold on to.
    lock    = (beat_q != '0) && (beat_q < BW'(MAX_BEATS)) && elig[last_q];
    sel     = lock ? last_q : rr_sel;
    grant   = (state_q == IDLE) && (lock || found);
    sel_rd  = sel[0];
    sel_ch  = CW'(sel >> 1);
    sel_nxt = (sel == SW'(NS - 1)) ? '0 : sel + 1'b1;
  end

  always_comb begin
    bus.ch_wr_ready  = '0;
    bus.ch_rd_aready = '0;
    if (grant) begin
      if (sel_rd) bus.ch_rd_aready[sel_ch] = 1'b1;
      else        bus.ch_wr_ready[sel_ch]  = 1'b1;
    end
  end

  // Orphan data is swallowed so the controller never stalls on it.
  always_comb begin
    bus.ch_rd_valid = '0;
    if (!tag_empty) bus.ch_rd_valid[head] = bus.m_rd_valid;
    bus.m_rd_ready = tag_empty ? bus.m_rd_valid : bus.ch_rd_ready[head];
  end

  assign bus.ch_rd_data  = {NUM_CH{bus.m_rd_data}};
  assign tag_push        = (state_q == RD) && bus.m_rd_aready;
  assign tag_pop         = bus.m_rd_valid && !tag_empty && bus.ch_rd_ready[head];

  assign bus.m_wr_data   = wr_data_q;
  assign bus.m_wr_addr   = wr_addr_q;
  assign bus.m_wr_valid  = wr_valid_q;
  assign bus.m_rd_addr   = rd_addr_q;
  assign bus.m_rd_avalid = rd_avalid_q;
  assign bus.err_orphan  = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      beat_q      <= '0;
      ch_q        <= '0;
      wr_data_q   <= '0;
      wr_addr_q   <= '0;
      rd_addr_q   <= '0;
      wr_valid_q  <= 1'b0;
      rd_avalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            last_q <= sel;
            ptr_q  <= sel_nxt;
            beat_q <= lock ? beat_q + 1'b1 : BW'(1);
            ch_q   <= sel_ch;
            if (sel_rd) begin
              rd_addr_q   <= bus.ch_rd_addr[sel_ch*AW +: AW];
              rd_avalid_q <= 1'b1;
              state_q     <= RD;
            end else begin
              wr_addr_q  <= bus.ch_wr_addr[sel_ch*AW +: AW];
              wr_data_q  <= bus.ch_wr_data[sel_ch*DW +: DW];
              wr_valid_q <= 1'b1;
              state_q    <= WR;
            end
          end
        end
        WR: begin
          if (bus.m_wr_ready) begin
            wr_valid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        RD: begin
          if (bus.m_rd_aready) begin
            rd_avalid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
      tag_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (tag_push) tag_wr_q <= tag_wr_q + 1'b1;
      if (tag_pop)  tag_rd_q <= tag_rd_q + 1'b1;
      if (tag_push && !tag_pop)      tag_cnt_q <= tag_cnt_q + 1'b1;
      else if (!tag_push && tag_pop) tag_cnt_q <= tag_cnt_q - 1'b1;
      if (bus.m_rd_valid && tag_empty) err_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_q] <= ch_q;
  end
endmodule

// File: tb/tb_sdram_port_arb.sv
// Randomized scoreboard bench for sdram_port_arb: a transaction-level arbitration model predicts
// grants, queues expected controller requests and read returns, and monitors compare them.
module tb_sdram_port_arb;
  localparam int NUM_CH = 4, DW = 16, AW = 24, MAX_OUTST = 4, MAX_BEATS = 4;
  localparam int NS = 2 * NUM_CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arb_if #(.NUM_CH(NUM_CH), .DW(DW), .AW(AW)) bus ();

  sdram_port_arb #(
    .NUM_CH(NUM_CH), .DW(DW), .AW(AW), .MAX_OUTST(MAX_OUTST), .MAX_BEATS(MAX_BEATS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {bit rd; int ch; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  typedef struct {int ch; logic [DW-1:0] data;} ret_t;

  req_t exp_req[$];
  ret_t exp_ret[$];
  int   mtag[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;

  // Client-side stimulus state
  bit            wr_v[NUM_CH], rd_v[NUM_CH];
  logic [AW-1:0] wr_a[NUM_CH], rd_a[NUM_CH];
  logic [DW-1:0] wr_d[NUM_CH];
  bit            init_v = 1'b0;

  // Arbitration model: slot granted last, how many times in a row, where the rotation resumes
  int last_slot = 0, run = 0, start = 0;
  bit busy = 1'b0, busy_rd = 1'b0;
  int grant_cyc = 0, outst = 0;

  // Controller-side stimulus state
  bit                b_en = 1'b0;
  int                ret_pct = 50;
  bit                wr_rdy_v = 1'b0, ard_v = 1'b0, rv_v = 1'b0, presenting = 1'b0;
  logic [DW-1:0]     rdat_v = '0;
  logic [NUM_CH-1:0] crr_v = '0;
  int                pres_ch = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic drive_clients();
    for (int i = 0; i < NUM_CH; i++) begin
      bus.ch_wr_valid[i]            = wr_v[i];
      bus.ch_wr_addr[i*AW +: AW]    = wr_a[i];
      bus.ch_wr_data[i*DW +: DW]    = wr_d[i];
      bus.ch_rd_avalid[i]           = rd_v[i];
      bus.ch_rd_addr[i*AW +: AW]    = rd_a[i];
    end
    bus.init_done = init_v;
  endtask

  // One cycle: predict the grant from the request set, compare, then update and drive.
  task automatic arb_cycle(input int wr_pct, input int rd_pct, input int init_pct);
    bit                elig[NS];
    int                exp_slot;
    bit                lock;
    logic [NUM_CH-1:0] ew, er;
    @(negedge clk);
    for (int s = 0; s < NS; s++)
      elig[s] = init_v && ((s % 2 == 0) ? wr_v[s/2] : (rd_v[s/2] && outst < MAX_OUTST));
    exp_slot = -1;
    lock     = 1'b0;
    if (!busy) begin
      if (run > 0 && run < MAX_BEATS && elig[last_slot]) begin
        exp_slot = last_slot;
        lock     = 1'b1;
      end else begin
        for (int k = 0; k < NS; k++)
          if (exp_slot < 0 && elig[(start + k) % NS]) exp_slot = (start + k) % NS;
      end
    end
    ew = '0;
    er = '0;
    if (exp_slot >= 0) begin
      if (exp_slot % 2 == 1) er[exp_slot/2] = 1'b1;
      else                   ew[exp_slot/2] = 1'b1;
    end
    check("grant_wr", bus.ch_wr_ready, ew);
    check("grant_rd", bus.ch_rd_aready, er);
    if (exp_slot >= 0) begin
      int c;
      c         = exp_slot / 2;
      run       = lock ? run + 1 : 1;
      last_slot = exp_slot;
      start     = (exp_slot + 1) % NS;
      busy      = 1'b1;
      busy_rd   = (exp_slot % 2 == 1);
      grant_cyc = cyc;
      if (busy_rd) begin
        exp_req.push_back('{rd: 1'b1, ch: c, addr: rd_a[c], data: '0});
        rd_v[c] = 1'b0;
      end else begin
        exp_req.push_back('{rd: 1'b0, ch: c, addr: wr_a[c], data: wr_d[c]});
        wr_v[c] = 1'b0;
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!wr_v[i] && $urandom_range(0, 99) < wr_pct) begin
        wr_v[i] = 1'b1;
        wr_a[i] = AW'($urandom);
        wr_d[i] = DW'($urandom);
      end
      if (!rd_v[i] && $urandom_range(0, 99) < rd_pct) begin
        rd_v[i] = 1'b1;
        rd_a[i] = AW'($urandom);
      end
    end
    init_v = ($urandom_range(0, 99) < init_pct);
    @(posedge clk);
    #1;
    drive_clients();
  endtask

  // Controller and read-data client behaviour
  always @(posedge clk) begin
    #1;
    if (b_en) begin
      wr_rdy_v = ($urandom_range(0, 99) < 65);
      ard_v    = ($urandom_range(0, 99) < 65);
      crr_v    = NUM_CH'($urandom);
      if (!presenting && mtag.size() > 0 && $urandom_range(0, 99) < ret_pct) begin
        pres_ch    = mtag.pop_front();
        rdat_v     = DW'($urandom);
        presenting = 1'b1;
        exp_ret.push_back('{ch: pres_ch, data: rdat_v});
      end
      rv_v = presenting;
    end
    bus.m_wr_ready  = wr_rdy_v;
    bus.m_rd_aready = ard_v;
    bus.m_rd_valid  = rv_v;
    bus.m_rd_data   = rdat_v;
    bus.ch_rd_ready = crr_v;
  end

  // Monitor: downstream requests and read returns against the scoreboard queues
  always @(negedge clk) begin
    #1;
    if (b_en) begin
      check("m_valids", {bus.m_wr_valid, bus.m_rd_avalid},
            (busy && cyc > grant_cyc) ? (busy_rd ? 2'b01 : 2'b10) : 2'b00);
      if (bus.m_wr_valid && exp_req.size() > 0 && !exp_req[0].rd) begin
        check("m_wr_addr", bus.m_wr_addr, exp_req[0].addr);
        check("m_wr_data", bus.m_wr_data, exp_req[0].data);
        if (wr_rdy_v) begin
          void'(exp_req.pop_front());
          busy = 1'b0;
        end
      end
      if (bus.m_rd_avalid && exp_req.size() > 0 && exp_req[0].rd) begin
        check("m_rd_addr", bus.m_rd_addr, exp_req[0].addr);
        if (ard_v) begin
          mtag.push_back(exp_req[0].ch);
          void'(exp_req.pop_front());
          outst++;
          busy = 1'b0;
        end
      end
      if (presenting && exp_ret.size() > 0) begin
        check("rd_valid", bus.ch_rd_valid, 64'(1) << exp_ret[0].ch);
        check("rd_data", bus.ch_rd_data[exp_ret[0].ch*DW +: DW], exp_ret[0].data);
        check("m_rd_ready", bus.m_rd_ready, crr_v[exp_ret[0].ch]);
        if (crr_v[exp_ret[0].ch]) begin
          void'(exp_ret.pop_front());
          presenting = 1'b0;
          outst--;
        end
      end else begin
        check("rd_idle", bus.ch_rd_valid, '0);
      end
      check("err_orphan", bus.err_orphan, 1'b0);
    end
  end

  function automatic bit drained();
    bit any = 1'b0;
    for (int i = 0; i < NUM_CH; i++) any |= wr_v[i] | rd_v[i];
    return !any && !busy && exp_req.size() == 0 && exp_ret.size() == 0 && mtag.size() == 0 &&
           outst == 0 && !presenting;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_v[i] = 1'b1;
      wr_a[i] = AW'(32'h10 * i);
      wr_d[i] = DW'(32'h100 + i);
      rd_v[i] = 1'b0;
      rd_a[i] = '0;
    end
    drive_clients();
    @(posedge clk);
    #2;
    check("rst_wr_ready", bus.ch_wr_ready, '0);
    check("rst_rd_aready", bus.ch_rd_aready, '0);
    check("rst_m_valids", {bus.m_wr_valid, bus.m_rd_avalid}, 2'b00);
    check("rst_m_wr_addr", bus.m_wr_addr, '0);
    check("rst_m_rd_ready", bus.m_rd_ready, 1'b0);
    check("rst_err", bus.err_orphan, 1'b0);
    @(negedge clk);
    rst  = 1'b0;
    b_en = 1'b1;
    @(posedge clk);
    #1;
    // init_done low: nothing may be granted even with every write requesting
    for (int n = 0; n < 20; n++) arb_cycle(0, 0, (n == 19) ? 100 : 0);
    ret_pct = 50;
    for (int n = 0; n < 1500; n++) arb_cycle(30, 20, 97);
    ret_pct = 4;
    for (int n = 0; n < 1500; n++) arb_cycle(30, 40, 97);
    ret_pct = 50;
    begin
      bit done = 1'b0;
      for (int n = 0; n < 2000 && !done; n++) begin
        arb_cycle(0, 0, 100);
        done = drained();
      end
      checks++;
      if (!done) begin
        errors++;
        $display("FAIL drain actual=pending required=empty (exp_req %0d outst %0d)",
                 exp_req.size(), outst);
      end
    end

    // Directed: orphan data, then reset while a read request is waiting downstream
    @(negedge clk);
    b_en     = 1'b0;
    wr_rdy_v = 1'b0;
    ard_v    = 1'b0;
    crr_v    = '0;
    rv_v     = 1'b1;
    rdat_v   = 16'h1234;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("orphan_m_rd_ready", bus.m_rd_ready, 1'b1);
    check("orphan_ch_rd_valid", bus.ch_rd_valid, '0);
    rv_v = 1'b0;
    @(posedge clk);
    #2;
    @(negedge clk);
    check("orphan_err", bus.err_orphan, 1'b1);
    check("orphan_ready_low", bus.m_rd_ready, 1'b0);
    @(posedge clk);
    #2;
    rd_v[1] = 1'b1;
    rd_a[1] = 24'hABCDEF;
    init_v  = 1'b1;
    drive_clients();
    @(negedge clk);
    check("dir_rd_aready", bus.ch_rd_aready, 4'b0010);
    @(posedge clk);
    #2;
    rd_v[1] = 1'b0;
    drive_clients();
    @(negedge clk);
    check("dir_m_rd_avalid", bus.m_rd_avalid, 1'b1);
    check("dir_m_rd_addr", bus.m_rd_addr, 24'hABCDEF);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_avalid", bus.m_rd_avalid, 1'b0);
    check("async_rst_addr", bus.m_rd_addr, '0);
    check("async_rst_err", bus.err_orphan, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sdram_port_arb.md
Name: sdram_port_arb

Overview:
- Multi-channel front end that multiplexes NUM_CH independent write/read client ports onto the single write/read request interface of the SDRAM controller top.
- Provides round-robin arbitration with a bounded same-channel burst lock, which preserves row locality.
- Records the channel of every outstanding read in an in-order tag FIFO and routes returned read data back to that channel.
- Sits between system clients (e.g. qspi bridge, DMA) and the SDRAM controller, in the controller clock domain.

Parameters:
- NUM_CH, 4, number of client channels (2..8).
- DW, 16, data width.
- AW, 24, address width.
- MAX_OUTST, 4, maximum outstanding reads, i.e. tag FIFO depth (power of 2).
- MAX_BEATS, 4, maximum consecutive grants to the same channel and type before forced rotation.

Ports:
- clk  in  1  controller clock
- rst  in  1  asynchronous active-high reset
- init_done  in  1  SDRAM initialisation complete; no grants issued while low
- ch_wr_data  in  NUM_CH*DW  per-channel write data, channel i at [i*DW +: DW]
- ch_wr_addr  in  NUM_CH*AW  per-channel write address
- ch_wr_valid  in  NUM_CH  write request
- ch_wr_ready  out  NUM_CH  write accepted
- ch_rd_addr  in  NUM_CH*AW  read address
- ch_rd_avalid  in  NUM_CH  read address request
- ch_rd_aready  out  NUM_CH  read address accepted
- ch_rd_data  out  NUM_CH*DW  read data, same word broadcast to all channels
- ch_rd_valid  out  NUM_CH  read data valid, one-hot
- ch_rd_ready  in  NUM_CH  client can take read data
- m_wr_data  out  DW  to controller wr_data
- m_wr_addr  out  AW  to controller wr_addr
- m_wr_valid  out  1  to controller wr_valid
- m_wr_ready  in  1  from controller wr_ready
- m_rd_addr  out  AW  to controller rd_addr
- m_rd_avalid  out  1  to controller rd_avalid
- m_rd_aready  in  1  from controller rd_aready
- m_rd_data  in  DW  from controller rd_data
- m_rd_valid  in  1  from controller rd_valid
- m_rd_ready  out  1  to controller rd_ready
- err_orphan  out  1  sticky: read data returned with no outstanding tag

Behaviour:

Clock and reset:
- One clock (clk); reset (rst) is asynchronous, active-high.

Reset values:
- All outputs 0: readies, m_*valid, m_*addr/data, err_orphan.
- FSM in IDLE, round-robin pointer 0, beat count 0, tag FIFO empty.

Requesters:
- 2*NUM_CH slots in the fixed order ch0.wr, ch0.rd, ch1.wr, ch1.rd, ...
- A read slot is eligible only when the tag FIFO is not full.
- No slot is eligible while init_done = 0.

FSM states: IDLE, WR, RD.

IDLE:
- Select the first eligible slot at or after the pointer, wrapping modulo 2*NUM_CH.
- Burst lock override: if last_slot is still eligible and beat_cnt < MAX_BEATS, select last_slot instead.
- On selection, assert the selected channel's ch_wr_ready or ch_rd_aready combinationally in the same cycle (that cycle is the client handshake).
- Register addr/data into m_*; next state is WR or RD.
- Pointer update: pointer <= selected+1 when the selection is a new slot or the lock expires. beat_cnt resets to 1 on a new slot and increments on a re-grant.

WR / RD:
- Hold m_wr_valid or m_rd_avalid high with stable payload until m_wr_ready or m_rd_aready, then return to IDLE.
- In RD, the downstream handshake pushes the granted channel index into the tag FIFO.
- No client ready is asserted in WR/RD.
- Client-to-controller latency is 1 cycle; peak rate is 1 request per 2 cycles.

Read return:
- head = tag FIFO head.
- ch_rd_valid[head] = m_rd_valid when the FIFO is not empty.
- m_rd_ready = ch_rd_ready[head].
- Pop on m_rd_valid & m_rd_ready.
- Push and pop in the same cycle leave the count unchanged; this is legal when the FIFO is full.

Orphan data:
- m_rd_valid while the tag FIFO is empty forces m_rd_ready = 1 (data dropped) and sets err_orphan until reset.

Boundary conditions:
- A client deasserting valid after grant is not possible: the handshake completed in IDLE.
- The tag FIFO at MAX_OUTST masks all read slots; writes continue.
- init_done falling while in WR/RD: the in-flight request completes; no further grants.
- Reset mid-operation: all state clears immediately and outstanding tags are discarded.

Test Plan:
1. Reset, init_done = 0, all ch_wr_valid = 1 -> no ch_wr_ready for 20 cycles. Raise init_done -> ch0 write granted first; m_wr_valid rises the next cycle.
2. All 4 channels continuously request writes (addresses 0x10*i), MAX_BEATS = 1, m_wr_ready = 1 -> m_wr_addr sequence 0x00, 0x10, 0x20, 0x30, 0x00, ...
3. Only ch2 writes continuously, MAX_BEATS = 4, ch1 requesting reads -> 4 consecutive ch2 grants, then ch1.rd, then ch2 again.
4. ch0 and ch3 issue reads, controller returns 0xAAAA then 0x5555 -> ch_rd_valid[0] with 0xAAAA, then ch_rd_valid[3] with 0x5555. Holding ch_rd_ready[0] = 0 stalls m_rd_ready.
5. 5 reads with no data return, MAX_OUTST = 4 -> 4 accepted and the 5th aready stays low. One data return accepts the 5th read.
6. m_rd_valid pulse with the FIFO empty -> err_orphan = 1 and m_rd_ready = 1. Assert rst mid-RD -> m_rd_avalid = 0 and err_orphan = 0 asynchronously.
